// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, frame constants and parity helper for the UART transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 11;

  localparam logic UART_IDLE_LEVEL  = 1'b0;
  localparam logic UART_START_LEVEL = 1'b1;
  localparam logic UART_STOP_LEVEL  = 1'b0;

  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - per-bit clock divider, restartable at each frame load
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_serialize.sv
// rtl/uart_serialize.sv - one-byte holding register feeding an 11-bit frame shifter
module uart_serialize
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_stream,
  output logic       busy,
  output logic       frame_done
);

  uart_tx_state_t state, state_next;
  logic [2:0]     bit_idx, bit_idx_next;
  logic [7:0]     hold, shreg;
  logic           hold_full, par;
  logic           load, accept, bit_end, line_next;

  assign tx_ready = !hold_full;
  assign accept   = tx_valid && !hold_full;
  assign busy     = (state != ST_IDLE);

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (load),
    .bit_end (bit_end)
  );

  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    load         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          load       = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next   = ST_DATA;
          bit_idx_next = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'(UART_DATA_BITS - 1)) state_next = ST_PARITY;
          else                                   bit_idx_next = bit_idx + 3'd1;
        end
      end
      ST_PARITY: begin
        if (bit_end) state_next = ST_STOP;
      end
      ST_STOP: begin
        // Reload straight from STOP so queued bytes go out with no idle gap.
        if (bit_end) begin
          if (hold_full) begin
            load       = 1'b1;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The line is registered, so it is driven from the level of the state being entered.
  always_comb begin
    line_next = UART_IDLE_LEVEL;
    case (state_next)
      ST_START:  line_next = UART_START_LEVEL;
      ST_DATA:   line_next = shreg[bit_idx_next];
      ST_PARITY: line_next = par;
      ST_STOP:   line_next = UART_STOP_LEVEL;
      default:   line_next = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_idx     <= 3'd0;
      hold        <= 8'h00;
      hold_full   <= 1'b0;
      shreg       <= 8'h00;
      par         <= 1'b0;
      uart_stream <= UART_IDLE_LEVEL;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_next;
      bit_idx     <= bit_idx_next;
      uart_stream <= line_next;
      frame_done  <= (state == ST_STOP) && bit_end;
      if (load) begin
        shreg     <= hold;
        par       <= uart_parity(hold);
        hold_full <= 1'b0;
      end else if (accept) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_serialize.sv
// tb/tb_uart_serialize.sv - directed and loopback bench for uart_serialize at 4 and 1 clocks per bit
module tb_uart_serialize;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d4, d1;
  logic       v4, v1;
  logic       r4, r1, l4, l1, b4, b1, f4, f1;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [7:0] sent[$];

  always #5 clk = ~clk;

  uart_serialize #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .tx_data(d4), .tx_valid(v4), .tx_ready(r4),
    .uart_stream(l4), .busy(b4), .frame_done(f4)
  );

  uart_serialize #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(v1), .tx_ready(r1),
    .uart_stream(l1), .busy(b1), .frame_done(f1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send one byte on the 4-clock instance and check every line sample of its frame.
  task automatic send4(input logic [7:0] d, input logic [10:0] f, input string tag);
    @(negedge clk);
    v4 = 1'b1;
    d4 = d;
    chk({tag, "_ready_before"}, r4, 1);
    @(negedge clk);
    v4 = 1'b0;
    chk({tag, "_ready_low"}, r4, 0);
    chk({tag, "_line_before_start"}, l4, 0);
    chk({tag, "_busy_before_start"}, b4, 0);
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk($sformatf("%s_bit%0d_c%0d", tag, k, c), l4, f[k]);
        chk($sformatf("%s_done_low%0d_c%0d", tag, k, c), f4, 0);
        chk($sformatf("%s_busy%0d_c%0d", tag, k, c), b4, 1);
      end
    end
    @(negedge clk);
    chk({tag, "_frame_done"}, f4, 1);
    chk({tag, "_line_idle"}, l4, 0);
    chk({tag, "_busy_idle"}, b4, 0);
    @(negedge clk);
    chk({tag, "_frame_done_pulse"}, f4, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] f_a, f_b, f_c;
    logic        e_line, e_rdy, e_fd, e_busy;

    rst_n = 1'b0;
    v4 = 1'b0; d4 = 8'h00;
    v1 = 1'b0; d1 = 8'h00;
    #2;
    chk("rst_line", l4, 0);
    chk("rst_ready", r4, 1);
    chk("rst_busy", b4, 0);
    chk("rst_done", f4, 0);
    chk("rst_ready_c1", r1, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send4(8'hA5, {1'b0, 1'b0, 8'hA5, 1'b1}, "a5");
    send4(8'h01, {1'b0, 1'b1, 8'h01, 1'b1}, "p01");
    send4(8'h00, {1'b0, 1'b0, 8'h00, 1'b1}, "p00");

    // Back-to-back at one clock per bit, third byte held off by backpressure.
    f_a = {1'b0, 1'b0, 8'h3C, 1'b1};
    f_b = {1'b0, 1'b0, 8'hFF, 1'b1};
    f_c = {1'b0, 1'b1, 8'h83, 1'b1};
    @(negedge clk);
    v1 = 1'b1;
    d1 = 8'h3C;
    chk("b2b_ready0", r1, 1);
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 11)       e_line = f_a[i-1];
      else if (i >= 12 && i <= 22) e_line = f_b[i-12];
      else if (i >= 23 && i <= 33) e_line = f_c[i-23];
      else                         e_line = 1'b0;
      e_rdy  = (i == 1) || (i == 12) || (i >= 23);
      e_fd   = (i == 12) || (i == 23) || (i == 34);
      e_busy = (i >= 1) && (i <= 33);
      chk($sformatf("b2b_line_%0d", i), l1, e_line);
      chk($sformatf("b2b_ready_%0d", i), r1, e_rdy);
      chk($sformatf("b2b_done_%0d", i), f1, e_fd);
      chk($sformatf("b2b_busy_%0d", i), b1, e_busy);
      if (i == 0)                d1 = 8'hFF;
      else if (i >= 2 && i <= 11) d1 = 8'h5A ^ 8'(i);
      else if (i == 12)          d1 = 8'h83;
      else if (i == 13)          v1 = 1'b0;
    end

    // Reset in the middle of DATA with a second byte waiting in hold.
    @(negedge clk);
    v4 = 1'b1;
    d4 = 8'hA5;
    @(negedge clk);
    v4 = 1'b0;
    @(negedge clk);
    v4 = 1'b1;
    d4 = 8'h11;
    @(negedge clk);
    v4 = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_in_data_line", l4, 1);
    chk("mid_hold_full", r4, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_line", l4, 0);
    chk("mid_rst_ready", r4, 1);
    chk("mid_rst_busy", b4, 0);
    chk("mid_rst_done", f4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_line_%0d", i), l4, 0);
      chk($sformatf("post_rst_busy_%0d", i), b4, 0);
    end

    // Loopback: producer streams random bytes, receiver model decodes the line.
    fork
      begin : producer
        int w;
        for (int n = 0; n < 256; n++) begin
          @(negedge clk);
          d4 = 8'($urandom);
          v4 = 1'b1;
          w  = 0;
          while (!r4 && w < 100) begin
            @(negedge clk);
            w++;
          end
          chk("lb_tx_timeout", 32'(w >= 100), 0);
          @(posedge clk);
          sent.push_back(d4);
        end
        @(negedge clk);
        v4 = 1'b0;
      end
      begin : receiver
        int          w;
        logic [10:0] bits;
        logic [7:0]  exp_b;
        for (int n = 0; n < 256; n++) begin
          w = 0;
          do begin
            @(negedge clk);
            w++;
          end while (l4 !== 1'b1 && w < 200);
          chk($sformatf("lb_start_seen_%0d", n), l4, 1);
          for (int k = 0; k < 11; k++) begin
            repeat ((k == 0) ? 2 : 4) @(negedge clk);
            bits[k] = l4;
          end
          @(negedge clk);
          if (sent.size() > 0) exp_b = sent.pop_front();
          else                 exp_b = 8'hxx;
          chk($sformatf("lb_start_%0d", n), bits[0], 1);
          chk($sformatf("lb_stop_%0d", n), bits[10], 0);
          chk($sformatf("lb_parity_%0d", n), bits[9], ^bits[8:1]);
          chk($sformatf("lb_data_%0d", n), bits[8:1], exp_b);
        end
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_serialize.md
# uart_serialize

- Transmit side of the BPSK UART link.
- Accepts bytes on a valid/ready handshake, buffers one byte, and shifts each out as an 11-bit frame on `uart_stream`.
- Frame order: start (1), 8 data bits LSB first, parity (XOR of data), stop (0).
- Sits between the packet source and the modulator, with the baud timing derived internally from the system clock.

## Interface
- `CLKS_PER_BIT`, default 16: system clocks per UART bit; legal values ≥ 1.
- `clk` input 1: system clock; all state on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `tx_data` input 8: byte to send; sampled on handshake.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: the holding register is empty; a byte is accepted when `tx_valid && tx_ready` at a rising edge.
- `uart_stream` output 1: serial line, registered; idle level 0.
- `busy` output 1: a frame is in progress (state ≠ IDLE).
- `frame_done` output 1: one-cycle pulse in the cycle after the last stop-bit cycle.

## Operation
- **Holding register.** One byte plus a `hold_full` flag.
  - `tx_ready = !hold_full`, combinational from the flag.
  - Accept sets `hold_full`; a load into the shift engine clears it.
- **Shift engine states.** IDLE, START, DATA, PARITY, STOP. `bit_idx` is 3 bits; the baud counter is `$clog2(CLKS_PER_BIT)` bits wide, minimum 1.
- **IDLE:** `uart_stream` = 0.
  - If `hold_full`: load the shift register from hold, latch `par = ^hold`, clear `hold_full`, reset the counter to 0, go to START.
- **START:** drive 1. At counter = `CLKS_PER_BIT-1`: go to DATA with `bit_idx` = 0.
- **DATA:** drive `shreg[bit_idx]`. At counter end:
  - `bit_idx` = 7 → go to PARITY;
  - otherwise increment `bit_idx`.
- **PARITY:** drive `par`; it is 1 when the byte has an odd number of ones. At counter end, go to STOP.
- **STOP:** drive 0. At counter end, pulse `frame_done`, then:
  - if `hold_full`: load as in IDLE and go straight to START, so there is no idle gap between frames;
  - else go to IDLE.
- **Counter.** Counts 0..`CLKS_PER_BIT-1` and wraps to 0 on every bit boundary. It is not free-running: it restarts at each frame load.
- **Holding-register writes during a frame.** A new byte may be accepted at any time while `hold_full` = 0, including during the frame in flight. It never corrupts the shift register.
- **Reset.**
  - Asynchronous reset forces: IDLE, `hold_full` = 0, counter = 0, `bit_idx` = 0, `uart_stream` = 0, `frame_done` = 0, `busy` = 0.
  - Consequently `tx_ready` = 1 after reset.
  - Reset mid-frame truncates the frame. The line drops to 0 immediately, and any held byte is discarded.

## Timing
- **Handshake to start bit, engine idle.**
  - Accept at edge N → `hold_full` after N → load at edge N+1.
  - `uart_stream` = 1 from edge N+1 for exactly `CLKS_PER_BIT` cycles. Latency is 2 clocks.
  - `tx_ready` is low for exactly the one cycle between N and N+1.
- **Frame length.** Exactly 11 × `CLKS_PER_BIT` cycles. Every bit is held for exactly `CLKS_PER_BIT` cycles.
- **Back-to-back frames.** If hold is full at the end of STOP, the next start bit begins on the cycle immediately after the last stop cycle.
- **`CLKS_PER_BIT` = 1.** One bit per clock. Sustained throughput is one byte per 11 clocks with continuous `tx_valid`.
- **No same-edge conflict.** Load and accept cannot coincide at the same edge, because `tx_ready` is low whenever hold is full.
- **`busy`.** Rises on the load edge and falls on the edge entering IDLE.

## Structure
- **Package `uart_pkg`:**
  - `uart_tx_state_t` enum;
  - `UART_DATA_BITS` = 8, `UART_FRAME_BITS` = 11;
  - `UART_IDLE_LEVEL` = 0, `UART_START_LEVEL` = 1, `UART_STOP_LEVEL` = 0;
  - function `uart_parity(byte)` returning the XOR reduction.
- **Sub-module `uart_baud_counter`.** Holds the counter.
  - Inputs: `clk`, `rst_n`, `restart`.
  - Output: `bit_end`, asserted when the counter = `CLKS_PER_BIT-1`.
- **Top level.** Holding register, shift register, and the FSM.

## Test plan
- **Reset.** Assert `rst_n` = 0 at random points, including mid-DATA. Required: `uart_stream` = 0, `tx_ready` = 1, `busy` = 0, `frame_done` = 0 asynchronously.
- **Single byte.**
  - Stimulus: `CLKS_PER_BIT` = 4, send 0xA5.
  - Required line sequence, each bit held 4 clocks: 1, 1,0,1,0,0,1,0,1, 0, 0.
  - Then: start bit 2 clocks after accept, `frame_done` after 44 cycles of frame, line idle at 0.
- **Parity.**
  - Send 0x01: parity bit = 1.
  - Send 0x00: the frame is 1, then nine 0s, then stop 0.
- **Back-to-back.**
  - Stimulus: `CLKS_PER_BIT` = 1, `tx_valid` held high with 0x3C then 0xFF.
  - Required: second accept while the first frame is in DATA; second start bit on the cycle right after the first stop; 22 cycles total.
  - 0xFF parity = 0.
- **Backpressure.**
  - Stimulus: a third byte offered while hold is full.
  - Required: `tx_ready` = 0 and the byte is not consumed until the STOP-to-START load frees hold. `tx_data` changes while `tx_valid && !tx_ready` have no effect.
- **Loopback.** 256 random bytes through a reference UART receiver model. All decoded with correct parity, in order, no drops.
